// File: rtl/food_seller_ctrl.sv
// Food-seller sequencing controller: coin credit, item arbitration against price/stock,
// dispense handshake and greedy coin-by-coin change payout.
module food_seller_ctrl #(
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned MAX_CREDIT = 50,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 3,
    parameter int unsigned PRICE0     = 15,
    parameter int unsigned PRICE1     = 20,
    parameter int unsigned PRICE2     = 25,
    parameter int unsigned PRICE3     = 35
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                sel_valid,
    input  logic [1:0]          sel_item,
    input  logic                cancel,
    output logic                disp_valid,
    output logic [1:0]          disp_item,
    input  logic                disp_ack,
    output logic                chg_valid,
    output logic [1:0]          chg_coin,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic [3:0]          sold_out,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                busy
);

    typedef enum logic [1:0] {StIdle, StDispense, StChange} state_e;

    state_e              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [STOCK_W-1:0]  r_stock [4];
    logic                r_disp_valid;
    logic [1:0]          r_disp_item;
    logic                r_chg_valid;
    logic [1:0]          r_chg_coin;
    logic [3:0]          r_sold_out;
    logic                r_coin_reject;
    logic                r_sel_err;
    logic                r_busy;

    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_chg_val;
    logic [CREDIT_W-1:0] w_price;
    logic [CREDIT_W:0]   w_coin_sum;
    logic                w_coin_fits;
    logic                w_sel_ok;
    logic [CREDIT_W-1:0] w_credit_sel;
    logic [CREDIT_W-1:0] w_credit_chg;

    function automatic logic [CREDIT_W-1:0] f_coin_val(input logic [1:0] t);
        logic [CREDIT_W-1:0] v;
        unique case (t)
            2'd0:    v = CREDIT_W'(1);
            2'd1:    v = CREDIT_W'(2);
            2'd2:    v = CREDIT_W'(5);
            default: v = CREDIT_W'(10);
        endcase
        return v;
    endfunction

    // Largest coin not exceeding amt; keeps chg_coin consistent with the credit it pays from.
    function automatic logic [1:0] f_greedy(input logic [CREDIT_W-1:0] amt);
        logic [1:0] c;
        if (amt >= CREDIT_W'(10))     c = 2'd3;
        else if (amt >= CREDIT_W'(5)) c = 2'd2;
        else if (amt >= CREDIT_W'(2)) c = 2'd1;
        else                          c = 2'd0;
        return c;
    endfunction

    always_comb begin
        w_coin_val = f_coin_val(coin_type);
        w_chg_val  = f_coin_val(r_chg_coin);
        unique case (sel_item)
            2'd0:    w_price = CREDIT_W'(PRICE0);
            2'd1:    w_price = CREDIT_W'(PRICE1);
            2'd2:    w_price = CREDIT_W'(PRICE2);
            default: w_price = CREDIT_W'(PRICE3);
        endcase
        w_coin_sum   = {1'b0, r_credit} + {1'b0, w_coin_val};
        w_coin_fits  = w_coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT);
        w_sel_ok     = (r_stock[sel_item] != '0) && (r_credit >= w_price);
        w_credit_sel = r_credit - w_price;
        w_credit_chg = r_credit - w_chg_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_credit      <= '0;
            for (int i = 0; i < 4; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
            r_disp_valid  <= 1'b0;
            r_disp_item   <= 2'd0;
            r_chg_valid   <= 1'b0;
            r_chg_coin    <= 2'd0;
            r_sold_out    <= (STOCK_INIT == 0) ? 4'hf : 4'h0;
            r_coin_reject <= 1'b0;
            r_sel_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_coin_reject <= 1'b0;
            r_sel_err     <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (cancel) begin
                        r_coin_reject <= coin_valid;
                        if (r_credit != '0) begin
                            r_state     <= StChange;
                            r_chg_valid <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end else if (sel_valid) begin
                        r_coin_reject <= coin_valid;
                        if (w_sel_ok) begin
                            r_credit             <= w_credit_sel;
                            r_chg_coin           <= f_greedy(w_credit_sel);
                            r_stock[sel_item]    <= r_stock[sel_item] - STOCK_W'(1);
                            r_sold_out[sel_item] <= (r_stock[sel_item] == STOCK_W'(1));
                            r_disp_item          <= sel_item;
                            r_disp_valid         <= 1'b1;
                            r_state              <= StDispense;
                            r_busy               <= 1'b1;
                        end else begin
                            r_sel_err <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (w_coin_fits) begin
                            r_credit   <= w_coin_sum[CREDIT_W-1:0];
                            r_chg_coin <= f_greedy(w_coin_sum[CREDIT_W-1:0]);
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end
                end
                StDispense: begin
                    r_coin_reject <= coin_valid;
                    if (disp_ack && r_disp_valid) begin
                        r_disp_valid <= 1'b0;
                        if (r_credit != '0) begin
                            r_state     <= StChange;
                            r_chg_valid <= 1'b1;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                StChange: begin
                    r_coin_reject <= coin_valid;
                    if (chg_ack && r_chg_valid) begin
                        r_credit   <= w_credit_chg;
                        r_chg_coin <= f_greedy(w_credit_chg);
                        if (w_credit_chg == '0) begin
                            r_chg_valid <= 1'b0;
                            r_state     <= StIdle;
                            r_busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign disp_valid  = r_disp_valid;
    assign disp_item   = r_disp_item;
    assign chg_valid   = r_chg_valid;
    assign chg_coin    = r_chg_coin;
    assign credit      = r_credit;
    assign sold_out    = r_sold_out;
    assign coin_reject = r_coin_reject;
    assign sel_err     = r_sel_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_food_seller_ctrl.sv
// Bench for food_seller_ctrl: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model of the machine.
module tb_food_seller_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       disp_valid;
    logic [1:0] disp_item;
    logic       disp_ack;
    logic       chg_valid;
    logic [1:0] chg_coin;
    logic       chg_ack;
    logic [7:0] credit;
    logic [3:0] sold_out;
    logic       coin_reject;
    logic       sel_err;
    logic       busy;

    always #5 clk = ~clk;

    food_seller_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .sel_valid  (sel_valid),
        .sel_item   (sel_item),
        .cancel     (cancel),
        .disp_valid (disp_valid),
        .disp_item  (disp_item),
        .disp_ack   (disp_ack),
        .chg_valid  (chg_valid),
        .chg_coin   (chg_coin),
        .chg_ack    (chg_ack),
        .credit     (credit),
        .sold_out   (sold_out),
        .coin_reject(coin_reject),
        .sel_err    (sel_err),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;

    int val_tab[4]   = '{1, 2, 5, 10};
    int price_tab[4] = '{15, 20, 25, 35};

    // Model: phase 0 = waiting for customer, 1 = item owed to dispenser, 2 = paying change.
    int m_phase;
    int m_credit;
    int m_stock[4];
    int m_item;
    int m_rej;
    int m_err;

    function automatic int greedy_idx(input int amount);
        for (int i = 3; i >= 0; i--) if (val_tab[i] <= amount) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_rej = 0;
        m_err = 0;
        if (!rst_n) begin
            m_phase  = 0;
            m_credit = 0;
            for (int i = 0; i < 4; i++) m_stock[i] = 3;
            m_item = 0;
        end else if (m_phase == 0) begin
            if (cancel) begin
                if (coin_valid) m_rej = 1;
                if (m_credit > 0) m_phase = 2;
            end else if (sel_valid) begin
                if (coin_valid) m_rej = 1;
                if (m_stock[sel_item] == 0 || m_credit < price_tab[sel_item]) begin
                    m_err = 1;
                end else begin
                    m_credit -= price_tab[sel_item];
                    m_stock[sel_item]--;
                    m_item  = sel_item;
                    m_phase = 1;
                end
            end else if (coin_valid) begin
                if (m_credit + val_tab[coin_type] <= 50) m_credit += val_tab[coin_type];
                else m_rej = 1;
            end
        end else if (m_phase == 1) begin
            if (coin_valid) m_rej = 1;
            if (disp_ack) m_phase = (m_credit > 0) ? 2 : 0;
        end else begin
            if (coin_valid) m_rej = 1;
            if (chg_ack) begin
                m_credit -= val_tab[greedy_idx(m_credit)];
                if (m_credit == 0) m_phase = 0;
            end
        end
    endtask

    task automatic check_all();
        int so;
        so = 0;
        for (int i = 0; i < 4; i++) if (m_stock[i] == 0) so |= (1 << i);
        chk("credit", int'(credit), m_credit);
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("disp_valid", int'(disp_valid), int'(m_phase == 1));
        chk("chg_valid", int'(chg_valid), int'(m_phase == 2));
        chk("sold_out", int'(sold_out), so);
        chk("coin_reject", int'(coin_reject), m_rej);
        chk("sel_err", int'(sel_err), m_err);
        if (m_phase == 1) chk("disp_item", int'(disp_item), m_item);
        if (m_phase == 2) chk("chg_coin", int'(chg_coin), greedy_idx(m_credit));
    endtask

    task automatic cyc(input bit cv, input int ct, input bit sv, input int si, input bit cn,
                       input bit da, input bit ca, input bit rst);
        logic [1:0] ct2, si2;
        ct2        = ct[1:0];
        si2        = si[1:0];
        coin_valid = cv;
        coin_type  = ct2;
        sel_valid  = sv;
        sel_item   = si2;
        cancel     = cn;
        disp_ack   = da;
        chg_ack    = ca;
        rst_n      = !rst;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
        disp_ack   = 1'b0;
        chg_ack    = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic idle();          cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic coin(input int t); cyc(1, t, 0, 0, 0, 0, 0, 0); endtask
    task automatic sel(input int i);  cyc(0, 0, 1, i, 0, 0, 0, 0); endtask
    task automatic cncl();          cyc(0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic dack();          cyc(0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic cack();          cyc(0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic rst();           cyc(0, 0, 0, 0, 0, 0, 0, 1); endtask

    initial begin
        coin_valid = 1'b0; coin_type = 2'd0; sel_valid = 1'b0; sel_item = 2'd0;
        cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0; rst_n = 1'b0;

        // Purchase with change
        rst(); rst();
        chk("reset_credit", int'(credit), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_sold_out", int'(sold_out), 0);
        coin(3); coin(2); coin(1);
        chk("credit_17", int'(credit), 17);
        chk("no_reject", int'(coin_reject), 0);
        sel(0);
        chk("disp_valid_1", int'(disp_valid), 1);
        chk("disp_item_0", int'(disp_item), 0);
        chk("credit_2", int'(credit), 2);
        idle(); idle(); idle();
        chk("disp_held", int'(disp_valid), 1);
        dack();
        chk("chg_valid_1", int'(chg_valid), 1);
        chk("chg_coin_2u", int'(chg_coin), 1);
        cack();
        chk("credit_0", int'(credit), 0);
        chk("busy_0", int'(busy), 0);

        // Insufficient credit, then refund
        coin(3);
        sel(3);
        chk("sel_err_price", int'(sel_err), 1);
        chk("credit_10_kept", int'(credit), 10);
        chk("no_disp", int'(disp_valid), 0);
        cncl();
        chk("refund_coin10", int'(chg_coin), 3);
        cack();
        chk("refund_done", int'(busy), 0);

        // Credit ceiling
        coin(3); coin(3); coin(3); coin(3); coin(2);
        coin(3);
        chk("over_reject", int'(coin_reject), 1);
        chk("credit_45", int'(credit), 45);
        coin(2);
        chk("credit_50", int'(credit), 50);
        cncl();
        for (int i = 0; i < 5; i++) begin
            chk("refund50_coin", int'(chg_coin), 3);
            cack();
        end
        chk("refund50_credit", int'(credit), 0);

        // Sell out item 1
        rst();
        for (int k = 0; k < 3; k++) begin
            coin(3); coin(3); sel(1); idle(); dack();
        end
        chk("sold_out_1", int'(sold_out), 4'b0010);
        coin(3); coin(3); sel(1);
        chk("sel_err_stock", int'(sel_err), 1);
        chk("credit_20_kept", int'(credit), 20);

        // Simultaneous strobes: cancel wins
        cyc(1, 0, 1, 0, 1, 0, 0, 0);
        chk("simul_reject", int'(coin_reject), 1);
        chk("simul_refund", int'(chg_valid), 1);
        chk("simul_no_disp", int'(disp_valid), 0);
        cack(); cack();
        coin(3); coin(3); sel(0);
        coin(0);
        chk("disp_coin_reject", int'(coin_reject), 1);
        chk("disp_credit_5", int'(credit), 5);
        dack(); cack();

        // Reset during change
        coin(2); coin(1); cncl();
        chk("chg7_valid", int'(chg_valid), 1);
        rst();
        chk("rst_chg_valid", int'(chg_valid), 0);
        chk("rst_credit", int'(credit), 0);
        chk("rst_sold_out", int'(sold_out), 0);
        chk("rst_busy", int'(busy), 0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom % 10) < 4, int'($urandom % 4), ($urandom % 10) < 2,
                int'($urandom % 4), ($urandom % 20) == 0, ($urandom % 2) == 1,
                ($urandom % 2) == 1, ($urandom % 500) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
